// File: rtl/dmi_uart_pkg.sv
// Shared constants for the UART-to-DMI debug transport: FSM states, DMI op/status codes,
// frame lengths and the baud divisor helper.
package dmi_uart_pkg;

  localparam int unsigned DmiAlen = 7;

  localparam logic [1:0] StCollect  = 2'd0;
  localparam logic [1:0] StRequest  = 2'd1;
  localparam logic [1:0] StResponse = 2'd2;
  localparam logic [1:0] StSend     = 2'd3;

  localparam logic [1:0] DMI_NOP   = 2'd0;
  localparam logic [1:0] DMI_READ  = 2'd1;
  localparam logic [1:0] DMI_WRITE = 2'd2;

  localparam logic [7:0] DMI_OK     = 8'd0;
  localparam logic [7:0] DMI_FAILED = 8'd2;
  localparam logic [7:0] DMI_BUSY   = 8'd3;

  localparam int unsigned CMD_BYTES = 6;
  localparam int unsigned RSP_BYTES = 5;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: pin synchroniser, start-bit glitch rejection, centre sampling and
// stop-bit check. byte_valid_o / frame_err_o pulse for one cycle at the stop-bit centre.
module uart_rx #(
  parameter int unsigned Div = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       busy_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(Div) + 1;
  localparam logic [CntW-1:0] BitEnd  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(Div / 2 - 1);

  localparam logic [1:0] RxIdle  = 2'd0;
  localparam logic [1:0] RxStart = 2'd1;
  localparam logic [1:0] RxData  = 2'd2;
  localparam logic [1:0] RxStop  = 2'd3;

  logic [1:0]      sync_q;
  logic            prev_q;
  logic            rx_s;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  assign rx_s        = sync_q[1];
  assign busy_o      = (state_q != RxIdle);
  assign byte_data_o = shift_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (prev_q && !rx_s) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfEnd) begin
          // A line back high at mid start bit was a glitch.
          state_d = rx_s ? RxIdle : RxData;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RxStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        if (cnt_q == BitEnd) begin
          cnt_d        = '0;
          state_d      = RxIdle;
          byte_valid_o = rx_s;
          frame_err_o  = !rx_s;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/dmi_uart_host.sv
// UART-to-DMI bridge: collects 6-byte command frames, issues one DMI request per frame and
// returns a 5-byte response frame (status, data LE) on the TX pin.
module dmi_uart_host
  import dmi_uart_pkg::*;
#(
  parameter int unsigned ClockHz     = 50_000_000,
  parameter int unsigned BaudRate    = 115200,
  parameter int unsigned TimeoutBits = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               rx_i,
  output logic               tx_o,
  output logic               dmi_req_valid_o,
  output logic [1:0]         dmi_req_op_o,
  output logic [DmiAlen-1:0] dmi_req_address_o,
  output logic [31:0]        dmi_req_data_o,
  input  logic               dmi_req_ready_i,
  input  logic               dmi_resp_valid_i,
  input  logic [1:0]         dmi_resp_op_i,
  input  logic [31:0]        dmi_resp_data_i,
  output logic               dmi_resp_ready_o
);

  localparam int unsigned Div       = baud_div(ClockHz, BaudRate);
  localparam int unsigned CntW      = $clog2(Div) + 1;
  localparam int unsigned ToCycles  = TimeoutBits * Div;
  localparam int unsigned ToW       = $clog2(ToCycles + 1);
  localparam logic [CntW-1:0] TxEnd = CntW'(Div - 1);
  localparam logic [ToW-1:0]  ToEnd = ToW'(ToCycles - 1);
  localparam logic [2:0] LastCmd    = 3'(CMD_BYTES - 1);
  localparam logic [2:0] LastRsp    = 3'(RSP_BYTES - 1);

  logic       rx_busy, rx_valid, rx_err;
  logic [7:0] rx_byte;

  uart_rx #(
    .Div (Div)
  ) u_uart_rx (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .busy_o       (rx_busy),
    .byte_valid_o (rx_valid),
    .byte_data_o  (rx_byte),
    .frame_err_o  (rx_err)
  );

  logic [1:0]         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [1:0]         op_q, op_d;
  logic [DmiAlen-1:0] addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [39:0]        txbuf_q, txbuf_d;
  logic               tx_q, tx_d;
  logic [CntW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [3:0]         tx_bit_q, tx_bit_d;
  logic [2:0]         tx_byte_q, tx_byte_d;
  logic [ToW-1:0]     to_cnt_q, to_cnt_d;
  logic               timeout, start_tx;
  logic [39:0]        tx_load;

  assign dmi_req_valid_o   = (state_q == StRequest);
  assign dmi_resp_ready_o  = (state_q == StResponse);
  assign dmi_req_op_o      = op_q;
  assign dmi_req_address_o = addr_q;
  assign dmi_req_data_o    = data_q;
  assign tx_o              = tx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    txbuf_d   = txbuf_q;
    tx_d      = tx_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_byte_d = tx_byte_q;
    to_cnt_d  = '0;
    timeout   = 1'b0;
    start_tx  = 1'b0;
    tx_load   = '0;

    // Idle timer only runs on a partial frame while the receiver is between bytes.
    if (state_q == StCollect && idx_q != 3'd0 && !rx_busy) begin
      if (to_cnt_q == ToEnd) timeout = 1'b1;
      else                   to_cnt_d = to_cnt_q + ToW'(1);
    end

    unique case (state_q)
      StCollect: begin
        if (timeout || rx_err) begin
          idx_d = '0;
        end else if (rx_valid) begin
          unique case (idx_q)
            3'd0:    op_d          = rx_byte[1:0];
            3'd1:    addr_d        = rx_byte[DmiAlen-1:0];
            3'd2:    data_d[7:0]   = rx_byte;
            3'd3:    data_d[15:8]  = rx_byte;
            3'd4:    data_d[23:16] = rx_byte;
            default: data_d[31:24] = rx_byte;
          endcase
          if (idx_q == LastCmd) begin
            idx_d = '0;
            unique case (op_q)
              DMI_READ, DMI_WRITE: state_d = StRequest;
              DMI_NOP: begin
                start_tx = 1'b1;
                tx_load  = {32'h0, DMI_OK};
              end
              default: begin
                start_tx = 1'b1;
                tx_load  = {32'h0, DMI_FAILED};
              end
            endcase
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StRequest: begin
        if (dmi_req_ready_i) state_d = StResponse;
      end
      StResponse: begin
        if (dmi_resp_valid_i) begin
          start_tx = 1'b1;
          tx_load  = {dmi_resp_data_i, 6'b0, dmi_resp_op_i};
        end
      end
      default: begin
        // tx_bit_q: 0 start, 1..8 data LSB first, 9 stop.
        if (tx_cnt_q == TxEnd) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            if (tx_byte_q == LastRsp) begin
              state_d = StCollect;
              tx_d    = 1'b1;
            end else begin
              tx_byte_d = tx_byte_q + 3'd1;
              tx_bit_d  = '0;
              tx_d      = 1'b0;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            if (tx_bit_q == 4'd8) begin
              tx_d = 1'b1;
            end else begin
              tx_d    = txbuf_q[0];
              txbuf_d = {1'b0, txbuf_q[39:1]};
            end
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
    endcase

    if (start_tx) begin
      state_d   = StSend;
      txbuf_d   = tx_load;
      tx_d      = 1'b0;
      tx_cnt_d  = '0;
      tx_bit_d  = '0;
      tx_byte_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StCollect;
      idx_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      txbuf_q   <= '0;
      tx_q      <= 1'b1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_byte_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      txbuf_q   <= txbuf_d;
      tx_q      <= tx_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_byte_q <= tx_byte_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_dmi_uart_host.sv
// Scoreboard bench for dmi_uart_host: directed frames on RX, a DM model answering requests,
// and a TX monitor comparing decoded bytes against queued expectations.
module tb_dmi_uart_host;
  import dmi_uart_pkg::*;

  localparam int unsigned Div        = 16;
  localparam int unsigned BitTimeout = 64;

  typedef struct packed {
    logic [1:0]         op;
    logic [DmiAlen-1:0] addr;
    logic [31:0]        data;
  } req_t;

  logic               clk = 1'b0;
  logic               rst_n, rx, tx;
  logic               req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0]         req_op, resp_op;
  logic [DmiAlen-1:0] req_addr;
  logic [31:0]        req_data, resp_data;

  int   checks = 0, errors = 0;
  int   n_req_seen = 0, n_req_exp = 0, n_tx_seen = 0;
  int   ready_delay = 0, resp_delay = 3;
  logic [1:0]  cfg_resp_op = 2'd0;
  logic [31:0] cfg_resp_data = 32'h0;
  bit   model_busy = 1'b0;
  req_t exp_req_q[$];
  logic [7:0] exp_tx_q[$];

  always #5 clk = ~clk;

  dmi_uart_host #(
    .ClockHz     (160),
    .BaudRate    (10),
    .TimeoutBits (BitTimeout)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .rx_i              (rx),
    .tx_o              (tx),
    .dmi_req_valid_o   (req_valid),
    .dmi_req_op_o      (req_op),
    .dmi_req_address_o (req_addr),
    .dmi_req_data_o    (req_data),
    .dmi_req_ready_i   (req_ready),
    .dmi_resp_valid_i  (resp_valid),
    .dmi_resp_op_i     (resp_op),
    .dmi_resp_data_i   (resp_data),
    .dmi_resp_ready_o  (resp_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic push_req(input logic [1:0] op, input logic [DmiAlen-1:0] addr,
                          input logic [31:0] data);
    req_t r;
    r.op = op; r.addr = addr; r.data = data;
    exp_req_q.push_back(r);
    n_req_exp++;
  endtask

  task automatic push_rsp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4);
    exp_tx_q.push_back(b0); exp_tx_q.push_back(b1); exp_tx_q.push_back(b2);
    exp_tx_q.push_back(b3); exp_tx_q.push_back(b4);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (Div) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    send_byte(b0, 1'b1); send_byte(b1, 1'b1); send_byte(b2, 1'b1);
    send_byte(b3, 1'b1); send_byte(b4, 1'b1); send_byte(b5, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_tx_q.size() != 0 || model_busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      fail_now({name, "_response"});
      exp_tx_q.delete();
    end
    repeat (3 * Div) @(negedge clk);
    chk({name, "_req_count"}, n_req_seen, n_req_exp);
    chk({name, "_req_pending"}, exp_req_q.size(), 0);
  endtask

  task automatic mon_wait(input int n, inout bit ok);
    repeat (n) begin
      @(negedge clk);
      if (!rst_n) ok = 1'b0;
    end
  endtask

  // DM model: checks the request against the queue, applies backpressure, then responds.
  initial begin : dm_model
    req_t e;
    bit   hs;
    int   n;
    req_ready = 1'b0; resp_valid = 1'b0; resp_op = 2'd0; resp_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && req_valid) begin
        model_busy = 1'b1;
        n_req_seen++;
        if (exp_req_q.size() != 0) begin
          e = exp_req_q.pop_front();
        end else begin
          checks++; errors++;
          $display("FAIL req_unexpected: actual op=%0d addr=%0h required=no request",
                   req_op, req_addr);
          e = '0;
        end
        for (int i = 0; i < ready_delay; i++) begin
          chk("req_hold_valid", req_valid, 1);
          chk("req_hold_fields", {req_op, req_addr, req_data}, e);
          @(negedge clk);
        end
        chk("req_op", req_op, e.op);
        chk("req_addr", req_addr, e.addr);
        chk("req_data", req_data, e.data);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("req_valid_drop", req_valid, 0);
        chk("resp_ready_rise", resp_ready, 1);
        repeat (resp_delay) @(negedge clk);
        resp_valid = 1'b1; resp_op = cfg_resp_op; resp_data = cfg_resp_data;
        n = 0; hs = 1'b0;
        while (!hs && n < 200) begin
          hs = resp_ready;
          @(negedge clk);
          n++;
        end
        if (!hs) fail_now("resp_handshake");
        resp_valid = 1'b0; resp_op = 2'd0; resp_data = 32'h0;
        model_busy = 1'b0;
      end
    end
  end

  // TX monitor: decodes 8N1 bytes at bit centres, aborting a byte cut by reset.
  initial begin : tx_mon
    logic       prev, stop;
    logic [7:0] b;
    bit         ok;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !tx) begin
        ok = 1'b1;
        mon_wait(Div / 2, ok);
        for (int i = 0; i < 8; i++) begin
          mon_wait(Div, ok);
          b[i] = tx;
        end
        mon_wait(Div, ok);
        stop = tx;
        if (ok) begin
          n_tx_seen++;
          chk("tx_stop", stop, 1);
          if (exp_tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: actual=%0h required=no byte", b);
          end else begin
            chk("tx_byte", b, exp_tx_q.pop_front());
          end
        end
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, base;
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_req_valid", req_valid, 0);
    chk("reset_resp_ready", resp_ready, 0);
    chk("reset_req_fields", {req_op, req_addr, req_data}, 0);
    rst_n = 1'b1;
    repeat (3 * Div) @(negedge clk);

    // Write, response after 3 cycles.
    push_req(2'd2, 7'h10, 32'h12345678);
    push_rsp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(8'h02, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12);
    wait_done("write");

    // Read with 20 cycles backpressure; response valid as soon as resp_ready rises.
    ready_delay = 20; resp_delay = 0; cfg_resp_data = 32'h00010C82;
    push_req(2'd1, 7'h11, 32'h0);
    push_rsp(8'h00, 8'h82, 8'h0C, 8'h01, 8'h00);
    send_frame(8'h01, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_done("read_backpressure");
    ready_delay = 0; resp_delay = 3; cfg_resp_data = 32'h0;

    // Nop (upper op bits ignored) and reserved op.
    push_rsp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(8'hFC, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A);
    wait_done("nop");
    push_rsp(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    wait_done("reserved");

    // Framing error after two good bytes, then a full frame.
    send_byte(8'h02, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h40, 1'b0);
    repeat (2 * Div) @(negedge clk);
    push_req(2'd2, 7'h22, 32'hCAFEF00D);
    push_rsp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(8'h02, 8'h22, 8'h0D, 8'hF0, 8'hFE, 8'hCA);
    wait_done("frame_err");

    // Idle timeout discards a 3-byte partial frame.
    send_byte(8'h01, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    repeat ((BitTimeout + 4) * Div) @(negedge clk);
    cfg_resp_data = 32'hDEADBEEF;
    push_req(2'd1, 7'h05, 32'h0);
    push_rsp(8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_frame(8'h01, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_done("timeout");

    // A gap shorter than the timeout keeps the partial frame.
    cfg_resp_data = 32'h0;
    push_req(2'd1, 7'h06, 32'h44332211);
    push_rsp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_byte(8'h01, 1'b1); send_byte(8'h06, 1'b1); send_byte(8'h11, 1'b1);
    repeat ((BitTimeout - 16) * Div) @(negedge clk);
    send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    wait_done("short_gap");

    // Busy status; bytes injected while the response is being sent are dropped.
    cfg_resp_op = DMI_BUSY[1:0]; cfg_resp_data = 32'h55AA1234;
    push_req(2'd2, 7'h2A, 32'h01020304);
    push_rsp(8'h03, 8'h34, 8'h12, 8'hAA, 8'h55);
    send_frame(8'h02, 8'h2A, 8'h04, 8'h03, 8'h02, 8'h01);
    repeat (3 * Div) @(negedge clk);
    send_byte(8'h01, 1'b1); send_byte(8'h7F, 1'b1);
    wait_done("busy");
    cfg_resp_op = 2'd0; cfg_resp_data = 32'h0;
    push_req(2'd2, 7'h01, 32'h0BADF00D);
    push_rsp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(8'h02, 8'h01, 8'h0D, 8'hF0, 8'hAD, 8'h0B);
    wait_done("after_busy");

    // Reset during the start bit of TX byte 3.
    cfg_resp_data = 32'h11223344;
    push_req(2'd1, 7'h04, 32'h0);
    exp_tx_q.push_back(8'h00);
    exp_tx_q.push_back(8'h44);
    base = n_tx_seen;
    send_frame(8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
    n = 0;
    while (n_tx_seen < base + 2 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) fail_now("reset_wait_bytes");
    n = 0;
    while (tx !== 1'b0 && n < 4 * Div) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4 * Div) fail_now("reset_wait_start");
    rst_n = 1'b0;
    #1;
    chk("reset_mid_tx", tx, 1);
    chk("reset_mid_req_valid", req_valid, 0);
    chk("reset_mid_resp_ready", resp_ready, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * Div) @(negedge clk);
    chk("reset_tx_pending", exp_tx_q.size(), 0);
    cfg_resp_data = 32'h0;
    push_req(2'd2, 7'h7E, 32'hA55A5AA5);
    push_rsp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(8'h02, 8'h7E, 8'hA5, 8'h5A, 8'h5A, 8'hA5);
    wait_done("after_reset");

    chk("final_tx_pending", exp_tx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmi_uart_host.md
# dmi_uart_host

Debug transport that bridges a UART link to the debug module's DMI port: it assembles fixed-length command frames from a serial RX pin, issues one DMI request per frame, and serialises the DMI response back on a TX pin. It sits directly upstream of `dm`, as the host side of `dmi_interface` in `top`. Its `rx`/`tx` pins are routed to two `gpio` header lines.

## Interface
- `ClockHz`, 50_000_000: frequency of `clk` in Hz.
- `BaudRate`, 115200: UART bit rate, 8N1 format.
- `TimeoutBits`, 64: bit-times of RX idle after which a partial frame is discarded.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset; one clock domain throughout.
- `rx`  in  1  UART receive pin; asynchronous; idle high.
- `tx`  out  1  UART transmit pin; idle high.
- `dmi`  dmi_if host modport  —  host side of the DMI interface, `DataWidth`=32, `AddressWidth`=`SYSTEM__DMI_ALEN`:
  - Request signals, driven: `req_valid`, `req_op[1:0]`, `req_address`, `req_data[31:0]`.
  - Request signal, sampled: `req_ready`.
  - Response signals, sampled: `resp_valid`, `resp_op[1:0]`, `resp_data[31:0]`.
  - Response signal, driven: `resp_ready`.

## Operation
- **Command frame:** 6 bytes, in order:
  - op byte: bits[1:0] give 0 nop, 1 read, 2 write, 3 reserved; bits[7:2] are ignored.
  - address byte: the low `SYSTEM__DMI_ALEN` bits are used.
  - 4 data bytes, little-endian.
- **Response frame:** 5 bytes: status byte (resp_op zero-extended), then 4 data bytes, little-endian.
- **FSM states:**
  - `COLLECT`: receives bytes. After byte 6:
    - read/write → `REQUEST`.
    - nop → `SEND` with status 0 and data 0; no DMI transaction.
    - reserved → `SEND` with status 2 and data 0.
  - `REQUEST`: `req_valid`=1; op, address and data are held stable until `req_ready`; then → `RESPONSE`.
  - `RESPONSE`: `resp_ready`=1; on `resp_valid` the bridge captures `resp_op` and `resp_data` and moves to `SEND`.
  - `SEND`: transmits 5 bytes back to back, then → `COLLECT` with the byte index cleared.
- **RX path:**
  - 2-flop synchroniser on `rx`.
  - Start bit detected on a falling edge and re-checked low at half a bit-time; a high re-check is a glitch and is ignored.
  - Data bits sampled at bit centres, LSB first.
  - Stop bit must be high. A framing error discards the byte and clears the frame index.
- **Bytes arriving outside `COLLECT`:** dropped. The host must wait for the response before sending the next frame.
- **Idle timeout:** if the frame index is non-zero and RX stays idle for `TimeoutBits` bit-times, the index clears to 0.
- **Divisor:** `(ClockHz + BaudRate/2) / BaudRate`, rounded to nearest. The counter width is `$clog2(divisor)+1`.
- **Reset (power-on or mid-operation):**
  - state `COLLECT`, frame index 0.
  - `tx`=1 immediately, even if a byte is cut short.
  - `req_valid`=0, `resp_ready`=0, all holding registers 0.

## Timing
- `req_valid` rises on the clock after the stop bit of byte 6 is sampled at its centre.
- Request hold: `req_op`, `req_address` and `req_data` must not change while `req_valid`=1 and `req_ready`=0.
- `req_valid` is low in the cycle after a cycle with `req_valid`=1 and `req_ready`=1.
- `resp_ready` rises in the cycle after the request handshake.
- If `resp_valid` is already high in that same cycle, the response is accepted in that cycle.
- The first TX start bit begins the cycle after the response handshake.
- TX bytes are sent back to back with exactly one stop bit each, so a response frame lasts 50 bit-times.
- Worst-case RX-to-request latency after the stop-bit centre: 1 cycle, plus 2 cycles of synchroniser delay on the pin.
- An idle timeout and a new start edge in the same cycle: the timeout wins, and the new byte becomes byte 1.

## Structure
- **Package `dmi_uart_pkg`:**
  - FSM state enum.
  - DMI op encodings (`DMI_NOP`=0, `DMI_READ`=1, `DMI_WRITE`=2).
  - Status codes (`DMI_OK`=0, `DMI_FAILED`=2, `DMI_BUSY`=3).
  - `CMD_BYTES`=6, `RSP_BYTES`=5.
- **Sub-module `uart_rx`:** synchroniser, baud counter, start/stop checking, and a `byte_valid`/`byte_data`/`frame_err` output.
- **TX shifter and command FSM:** stay in the top module of the block.

## Test plan
- Write:
  - stimulus: RX `02 10 78 56 34 12`; DM model responds op 0 after 3 cycles.
  - required: `req_op`=2, `req_address`=0x10, `req_data`=0x12345678.
  - required: TX returns `00 00 00 00 00` (status byte then 4 data bytes) when the model returns data 0.
- Read with backpressure:
  - stimulus: RX `01 11 00 00 00 00`; `req_ready` held low 20 cycles; response data 0x00010C82.
  - required: request fields stable for all 20 cycles.
  - required: TX returns `00 82 0C 01 00`.
- Nop and reserved ops:
  - RX `00 …` → TX `00 00 00 00 00`; `req_valid` never asserts.
  - RX `03 …` → TX `02 00 00 00 00`; `req_valid` never asserts.
- Framing error and timeout:
  - stimulus: a byte with its stop bit low after 2 good bytes, then a full valid frame.
  - required: exactly one DMI request, decoded from the full frame.
  - stimulus: 3 bytes, then 64 bit-times idle, then a full frame.
  - required: the request is decoded from the full frame.
- Busy status and dropped bytes:
  - stimulus: model returns op 3; RX bytes are injected during `SEND`.
  - required: TX status byte is 0x03; the injected bytes are ignored.
  - required: the next frame decodes correctly.
- Reset mid-transfer:
  - stimulus: assert `rst_n` low during TX byte 3.
  - required: `tx`=1, `req_valid`=0, `resp_ready`=0 before the next clock edge.
  - required: the next frame after reset is handled normally.
